// File: rtl/execute_flag_checkpoint_register.sv
// Execute-stage architectural flag register with a LIFO of flag checkpoints for branch/exception recovery.
// Optional feature: define EXECUTE_FLAG_STICKY_EN to make flag bit STICKY_IDX accumulate across execute updates.
module execute_flag_checkpoint_register #(
  parameter int unsigned FLAG_W     = 5,
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned CP_DEPTH   = 4,
  parameter int unsigned STICKY_IDX = 3
) (
  input  logic                        iCLOCK,
  input  logic                        inRESET,
  input  logic                        iRESET_SYNC,
  input  logic                        iCTRL_HOLD,
  input  logic                        iPFLAGR_VALID,
  input  logic [FLAG_W-1:0]           iPFLAGR,
  input  logic                        iPREV_INST_VALID,
  input  logic                        iPREV_BUSY,
  input  logic                        iPREV_FLAG_WRITE,
  input  logic [N_SRC-1:0]            iSRC_VALID,
  input  logic [N_SRC*FLAG_W-1:0]     iSRC_FLAG,
  input  logic                        iCP_SAVE,
  input  logic                        iCP_RESTORE,
  input  logic                        iCP_DISCARD,
  output logic [FLAG_W-1:0]           oFLAG,
  output logic                        oFLAG_UPDATE,
  output logic [$clog2(CP_DEPTH):0]   oCP_COUNT,
  output logic                        oCP_FULL,
  output logic                        oCP_EMPTY,
  output logic                        oCP_ERR
);

  localparam int unsigned AW = $clog2(CP_DEPTH);
  localparam int unsigned CW = AW + 1;

`ifdef EXECUTE_FLAG_STICKY_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif
  localparam logic [FLAG_W-1:0] STICKY_MASK = STICKY_ON ? (FLAG_W'(1) << STICKY_IDX) : '0;

  logic [FLAG_W-1:0] flag_q, flag_d;
  logic              upd_q, upd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              err_q, err_d;
  logic [FLAG_W-1:0] lifo_q [CP_DEPTH];

  logic [FLAG_W-1:0] src_sel;
  logic [FLAG_W-1:0] exec_flag;
  logic [AW-1:0]     top_idx;
  logic              exec_go;
  logic              save_sel, discard_sel, conflict;
  logic              restore_ok, save_ok, discard_ok;
  logic              is_full, is_empty;

  // Lowest-index valid source wins
  always_comb begin
    src_sel = '0;
    for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
      if (iSRC_VALID[k]) src_sel = iSRC_FLAG[k*FLAG_W +: FLAG_W];
    end
  end

  assign exec_flag = src_sel | (flag_q & STICKY_MASK);
  assign exec_go   = !iPREV_BUSY && iPREV_INST_VALID && iPREV_FLAG_WRITE && (|iSRC_VALID);

  assign is_full     = (cnt_q == CW'(CP_DEPTH));
  assign is_empty    = (cnt_q == '0);
  assign top_idx     = AW'(cnt_q - CW'(1));
  assign save_sel    = iCP_SAVE && !iCP_RESTORE;
  assign discard_sel = iCP_DISCARD && !iCP_RESTORE && !iCP_SAVE;
  assign conflict    = (iCP_RESTORE && (iCP_SAVE || iCP_DISCARD)) || (iCP_SAVE && iCP_DISCARD);
  assign restore_ok  = !iCTRL_HOLD && iCP_RESTORE && !is_empty;
  assign save_ok     = !iCTRL_HOLD && save_sel && !is_full;
  assign discard_ok  = !iCTRL_HOLD && discard_sel && !is_empty;

  // Next-state for flags, checkpoint count and error
  always_comb begin
    flag_d  = flag_q;
    upd_d   = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (iRESET_SYNC) begin
      flag_d = '0;
      cnt_d  = '0;
      err_d  = 1'b0;
    end else begin
      if (iPFLAGR_VALID) begin
        flag_d = iPFLAGR;
      end else if (restore_ok) begin
        flag_d = lifo_q[top_idx];
      end else if (!iCTRL_HOLD && exec_go) begin
        flag_d = exec_flag;
        upd_d  = 1'b1;
      end
      if (restore_ok || discard_ok) begin
        cnt_d = cnt_q - CW'(1);
      end else if (save_ok) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (!iCTRL_HOLD && (conflict || (iCP_RESTORE && is_empty) ||
                          (discard_sel && is_empty) || (save_sel && is_full))) begin
        err_d = 1'b1;
      end
    end
    full_d  = (cnt_d == CW'(CP_DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      flag_q  <= '0;
      upd_q   <= 1'b0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      flag_q  <= flag_d;
      upd_q   <= upd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  // Checkpoint storage needs no reset; only entries below the count are ever read
  always_ff @(posedge iCLOCK) begin
    if (!iRESET_SYNC && save_ok) lifo_q[cnt_q[AW-1:0]] <= flag_q;
  end

  assign oFLAG        = flag_q;
  assign oFLAG_UPDATE = upd_q;
  assign oCP_COUNT    = cnt_q;
  assign oCP_FULL     = full_q;
  assign oCP_EMPTY    = empty_q;
  assign oCP_ERR      = err_q;

endmodule

// File: tb/tb_execute_flag_checkpoint_register.sv
// Bench for execute_flag_checkpoint_register: directed scenarios plus random traffic against a queue-based model.
module tb_execute_flag_checkpoint_register;

  localparam int unsigned FLAG_W   = 5;
  localparam int unsigned N_SRC    = 4;
  localparam int unsigned CP_DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    sync, hold, pv, inst_v, busy, fw, save, restore, discard;
  logic [FLAG_W-1:0]       pdata;
  logic [N_SRC-1:0]        sv;
  logic [N_SRC*FLAG_W-1:0] sf;
  logic [FLAG_W-1:0]       o_flag;
  logic                    o_upd, o_full, o_empty, o_err;
  logic [2:0]              o_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [FLAG_W-1:0] m_flag = '0;
  logic              m_upd  = 1'b0;
  logic              m_err  = 1'b0;
  logic [FLAG_W-1:0] stack [$];

  execute_flag_checkpoint_register #(
    .FLAG_W(FLAG_W), .N_SRC(N_SRC), .CP_DEPTH(CP_DEPTH), .STICKY_IDX(3)
  ) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(sync), .iCTRL_HOLD(hold),
    .iPFLAGR_VALID(pv), .iPFLAGR(pdata), .iPREV_INST_VALID(inst_v), .iPREV_BUSY(busy),
    .iPREV_FLAG_WRITE(fw), .iSRC_VALID(sv), .iSRC_FLAG(sf), .iCP_SAVE(save),
    .iCP_RESTORE(restore), .iCP_DISCARD(discard), .oFLAG(o_flag), .oFLAG_UPDATE(o_upd),
    .oCP_COUNT(o_cnt), .oCP_FULL(o_full), .oCP_EMPTY(o_empty), .oCP_ERR(o_err)
  );

  always #5 clk = ~clk;

  // Reference model: rules applied to a queue that stands in for the checkpoint stack
  task automatic model_step();
    logic [FLAG_W-1:0] nf, popv;
    logic              popped, nu;
    nf = m_flag; popv = '0; popped = 1'b0; nu = 1'b0;
    if (sync) begin
      m_flag = '0; m_upd = 1'b0; m_err = 1'b0; stack.delete();
      return;
    end
    if (!hold) begin
      if (restore) begin
        if (save || discard) m_err = 1'b1;
        if (stack.size() == 0) m_err = 1'b1;
        else begin popv = stack.pop_back(); popped = 1'b1; end
      end else if (save) begin
        if (discard) m_err = 1'b1;
        if (stack.size() == int'(CP_DEPTH)) m_err = 1'b1;
        else stack.push_back(m_flag);
      end else if (discard) begin
        if (stack.size() == 0) m_err = 1'b1;
        else void'(stack.pop_back());
      end
    end
    if (pv) nf = pdata;
    else if (popped) nf = popv;
    else if (!hold && !busy && inst_v && fw && sv != '0) begin
      for (int k = 0; k < int'(N_SRC); k++) begin
        if (sv[k]) begin nf = sf[k*FLAG_W +: FLAG_W]; break; end
      end
`ifdef EXECUTE_FLAG_STICKY_EN
      nf[3] = nf[3] | m_flag[3];
`endif
      nu = 1'b1;
    end
    m_flag = nf;
    m_upd  = nu;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sync = 0; hold = 0; pv = 0; pdata = '0; inst_v = 0; busy = 0; fw = 0;
    sv = '0; sf = '0; save = 0; restore = 0; discard = 0;
  endtask

  task automatic do_sync();
    idle(); sync = 1; cycle(); sync = 0;
  endtask

  task automatic exec(input logic [FLAG_W-1:0] f);
    idle(); inst_v = 1; fw = 1; sv = 4'b0001; sf = {15'h0, f};
  endtask

  task automatic test_reset();
    idle(); rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_flag, o_upd, o_cnt, o_full, o_empty, o_err} !== {5'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: got flag=%h upd=%b cnt=%0d full=%b empty=%b err=%b, want 00/0/0/0/1/0",
               o_flag, o_upd, o_cnt, o_full, o_empty, o_err);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_src_priority();
    do_sync();
    inst_v = 1; fw = 1; sv = 4'b1010; sf = {5'h11, 5'h00, 5'h0A, 5'h00};
    cycle();
    n_cmp++;
    if ({o_flag, o_upd} !== {5'h0A, 1'b1}) begin
      n_bad++; $display("FAIL src_priority: flag=%h upd=%b, want 0a/1", o_flag, o_upd);
    end
    idle(); cycle();
    n_cmp++;
    if ({o_flag, o_upd} !== {5'h0A, 1'b0}) begin
      n_bad++; $display("FAIL upd_pulse: flag=%h upd=%b, want 0a/0", o_flag, o_upd);
    end
    inst_v = 1; fw = 1; sv = '0; sf = {4{5'h1F}};
    cycle();
    sv = 4'b0100; busy = 1;
    cycle();
    n_cmp++;
    if ({o_flag, o_upd} !== {5'h0A, 1'b0}) begin
      n_bad++; $display("FAIL no_src_or_busy: flag=%h upd=%b, want 0a/0", o_flag, o_upd);
    end
  endtask

  task automatic test_save_restore();
    do_sync();
    pv = 1; pdata = 5'h03; cycle();
    n_cmp++;
    if ({o_flag, o_upd} !== {5'h03, 1'b0}) begin
      n_bad++; $display("FAIL pflagr_write: flag=%h upd=%b, want 03/0", o_flag, o_upd);
    end
    idle(); save = 1; cycle();
    n_cmp++;
    if (o_cnt !== 3'd1) begin
      n_bad++; $display("FAIL save_count: cnt=%0d, want 1", o_cnt);
    end
    exec(5'h1C); cycle();
    idle(); restore = 1; cycle();
    n_cmp++;
    if ({o_flag, o_upd, o_cnt, o_empty, o_err} !== {5'h03, 1'b0, 3'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL restore: flag=%h upd=%b cnt=%0d empty=%b err=%b, want 03/0/0/1/0",
               o_flag, o_upd, o_cnt, o_empty, o_err);
    end
  endtask

  task automatic test_overflow_discard();
    do_sync();
    pv = 1; pdata = 5'h12; cycle();
    idle(); save = 1;
    repeat (CP_DEPTH + 1) cycle();
    n_cmp++;
    if ({o_cnt, o_full, o_empty, o_err} !== {3'd4, 1'b1, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL overflow: cnt=%0d full=%b empty=%b err=%b, want 4/1/0/1",
                        o_cnt, o_full, o_empty, o_err);
    end
    idle(); discard = 1;
    repeat (CP_DEPTH) cycle();
    n_cmp++;
    if ({o_flag, o_cnt, o_full, o_empty} !== {5'h12, 3'd0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL discard_all: flag=%h cnt=%0d full=%b empty=%b, want 12/0/0/1",
                        o_flag, o_cnt, o_full, o_empty);
    end
  endtask

  task automatic test_conflict();
    do_sync();
    pv = 1; pdata = 5'h07; cycle();
    idle(); save = 1; cycle();
    idle(); pv = 1; pdata = 5'h1E; cycle();
    idle(); save = 1; restore = 1; cycle();
    n_cmp++;
    if ({o_flag, o_cnt, o_err} !== {5'h07, 3'd0, 1'b1}) begin
      n_bad++; $display("FAIL save_restore_conflict: flag=%h cnt=%0d err=%b, want 07/0/1",
                        o_flag, o_cnt, o_err);
    end
    do_sync();
    exec(5'h05); restore = 1; cycle();
    n_cmp++;
    if ({o_flag, o_upd, o_cnt, o_err} !== {5'h05, 1'b1, 3'd0, 1'b1}) begin
      n_bad++; $display("FAIL restore_underflow: flag=%h upd=%b cnt=%0d err=%b, want 05/1/0/1",
                        o_flag, o_upd, o_cnt, o_err);
    end
  endtask

  task automatic test_hold_async();
    do_sync();
    pv = 1; pdata = 5'h0B; cycle();
    exec(5'h1F); hold = 1; save = 1; cycle();
    n_cmp++;
    if ({o_flag, o_upd, o_cnt, o_err} !== {5'h0B, 1'b0, 3'd0, 1'b0}) begin
      n_bad++; $display("FAIL hold_freeze: flag=%h upd=%b cnt=%0d err=%b, want 0b/0/0/0",
                        o_flag, o_upd, o_cnt, o_err);
    end
    idle(); hold = 1; pv = 1; pdata = 5'h15; cycle();
    n_cmp++;
    if (o_flag !== 5'h15) begin
      n_bad++; $display("FAIL hold_pflagr: flag=%h, want 15", o_flag);
    end
    idle(); save = 1; cycle();
    save = 1; discard = 1; cycle();
    n_cmp++;
    if ({o_cnt, o_err} !== {3'd2, 1'b1}) begin
      n_bad++; $display("FAIL save_discard_conflict: cnt=%0d err=%b, want 2/1", o_cnt, o_err);
    end
    idle();
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({o_flag, o_upd, o_cnt, o_full, o_empty, o_err} !== {5'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL async_reset: flag=%h upd=%b cnt=%0d full=%b empty=%b err=%b",
                        o_flag, o_upd, o_cnt, o_full, o_empty, o_err);
    end
    m_flag = '0; m_upd = 1'b0; m_err = 1'b0; stack.delete();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_sticky();
    logic [FLAG_W-1:0] want;
`ifdef EXECUTE_FLAG_STICKY_EN
    want = 5'h09;
`else
    want = 5'h01;
`endif
    do_sync();
    exec(5'h08); cycle();
    exec(5'h01); cycle();
    n_cmp++;
    if (o_flag !== want) begin
      n_bad++; $display("FAIL sticky: flag=%h, want %h", o_flag, want);
    end
  endtask

  task automatic test_random();
    do_sync();
    for (int i = 0; i < 600; i++) begin
      sync    = ($urandom_range(0, 40) == 0);
      hold    = ($urandom_range(0, 5) == 0);
      pv      = ($urandom_range(0, 7) == 0);
      pdata   = FLAG_W'($urandom);
      inst_v  = ($urandom_range(0, 3) != 0);
      busy    = ($urandom_range(0, 4) == 0);
      fw      = ($urandom_range(0, 3) != 0);
      sv      = N_SRC'($urandom);
      sf      = (N_SRC*FLAG_W)'($urandom);
      save    = ($urandom_range(0, 2) == 0);
      restore = ($urandom_range(0, 4) == 0);
      discard = ($urandom_range(0, 5) == 0);
      cycle();
      n_cmp++;
      if ({o_flag, o_upd, o_cnt, o_full, o_empty, o_err} !==
          {m_flag, m_upd, 3'(stack.size()), stack.size() == int'(CP_DEPTH), stack.size() == 0, m_err}) begin
        n_bad++;
        $display("FAIL random[%0d]: flag=%h upd=%b cnt=%0d full=%b empty=%b err=%b, want flag=%h upd=%b cnt=%0d err=%b",
                 i, o_flag, o_upd, o_cnt, o_full, o_empty, o_err, m_flag, m_upd, stack.size(), m_err);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_src_priority();
    test_save_restore();
    test_overflow_discard();
    test_conflict();
    test_hold_async();
    test_sticky();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
